multi_debouncer: RTL and testbench
==================================

# multi_debouncer

Parametrised N-channel push-button debouncer with edge-event and long-press reporting, the next generation of the single-channel button debouncer. Each channel synchronises its raw input, qualifies press and release against a shared timing tick (e.g. 16 ms strobe from the prescaler), and emits a stable level plus single-cycle press/release/long-press pulses. It sits between the board button pins and the game control FSM, replacing one debouncer instance per button.

## Interface
- CHANNELS, 4: number of independent button channels (≥1)
- STABLE_TICKS, 2: consecutive ticks input must hold a new value before it is accepted (1..2^CNT_W−1)
- CNT_W, 4: width of per-channel stability counter
- LONG_TICKS, 64: ticks of continuous HELD before long_press fires (≥1)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- tick  in  1  single-cycle timing strobe shared by all channels
- p_in  in  CHANNELS  raw asynchronous button inputs, active-high
- level  out  CHANNELS  debounced level
- press  out  CHANNELS  1-cycle pulse on accepted press
- release  out  CHANNELS  1-cycle pulse on accepted release
- long_press  out  CHANNELS  1-cycle pulse when hold reaches LONG_TICKS
- busy  out  CHANNELS  channel is qualifying a transition (PRESS_WAIT or RELEASE_WAIT)

## Operation
- Per channel: 2-FF synchroniser p_in[i] -> s[i]; FSM uses s[i] only.
- States: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT; stability counter cnt; hold counter hcnt (width $clog2(LONG_TICKS+1), saturating).
- IDLE: s=1 -> PRESS_WAIT, cnt<=0.
- PRESS_WAIT: s=0 -> IDLE (abort, no pulse); else on tick cnt<=cnt+1; when cnt+1==STABLE_TICKS -> HELD, hcnt<=0, press pulse.
- HELD: s=0 -> RELEASE_WAIT, cnt<=0; else on tick hcnt increments, saturating at LONG_TICKS; long_press pulses exactly once, on the tick where hcnt reaches LONG_TICKS.
- RELEASE_WAIT: s=1 -> HELD (bounce; hcnt kept, no pulse); else on tick cnt<=cnt+1; when cnt+1==STABLE_TICKS -> IDLE, release pulse.
- Simultaneous events: input change beats tick (abort/return takes precedence over counting in same cycle).
- Ticks counted only when FSM is already in the wait state at that edge; tick in the entry cycle is ignored.
- level=1 in HELD and RELEASE_WAIT; 0 in IDLE and PRESS_WAIT. busy=1 in PRESS_WAIT and RELEASE_WAIT.
- Channels fully independent; no arbitration; any number of pulses may assert in the same cycle.
- hcnt does not count while in RELEASE_WAIT.

## Timing
- All outputs registered; reset value of level, press, release, long_press, busy, synchronisers, counters: all 0; FSMs IDLE.
- Reset mid-operation: next cycle all outputs 0, no release/press pulse emitted for aborted state.
- Input-to-synchronised latency: 2 clk.
- press asserted in the first cycle the state register reads HELD, same cycle level rises; release in first IDLE cycle, same cycle level falls.
- Press latency: 2 clk + STABLE_TICKS ticks (+1 clk state/output register); pulses exactly 1 clk wide.
- STABLE_TICKS=1: first tick seen in wait state completes qualification.

## Configuration
- DEBOUNCE_LONGPRESS_EN defined: hcnt and long_press logic present as above.
- Not defined: hcnt removed, long_press driven constant 0; all other behaviour identical.

## Test plan
- Reset: rst=1 for 3 cycles with p_in=4'b1111 -> all outputs 0; after release, channel states IDLE until synchroniser propagates.
- Clean press ch0, CHANNELS=4, STABLE_TICKS=2, tick every 8 clk: hold p_in[0]=1 -> press[0] one 1-clk pulse, level[0]=1 after 2nd counted tick; busy[0]=1 in between; other channels silent.
- Bounce: p_in[1] high for 1 tick then low before 2nd tick -> no press, level[1]=0, busy[1] returns 0; release bounce in HELD (low for <2 ticks) -> level stays 1, no release.
- Release: after ch2 HELD, drive 0 for 2 ticks -> release[2] 1-clk pulse, level[2]=0 same cycle.
- Long press (macro on, LONG_TICKS=4): hold ch3 for 10 ticks -> exactly one long_press[3] pulse on 4th tick in HELD; macro off -> long_press stays 0.
- Simultaneous: p_in drops in same cycle as completing tick in PRESS_WAIT -> IDLE, no press; reset asserted in HELD -> no release pulse, level=0 next cycle.

Source files
------------

// File: rtl/multi_debouncer.sv
// N-channel push-button debouncer with press/release/long-press pulses.
// Optional long-press logic is enabled by defining DEBOUNCE_LONGPRESS_EN.
module multi_debouncer #(
    parameter int CHANNELS     = 4,
    parameter int STABLE_TICKS = 2,
    parameter int CNT_W        = 4,
    parameter int LONG_TICKS   = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic [CHANNELS-1:0] p_in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] long_press,
    output logic [CHANNELS-1:0] busy
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // cnt + 1 == STABLE_TICKS is tested as cnt == STABLE_TICKS - 1 so the sum never overflows
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_TICKS - 1);

    if (CHANNELS < 1 || STABLE_TICKS < 1 || STABLE_TICKS > (2 ** CNT_W) - 1 || LONG_TICKS < 1) begin : g_bad_params
        $error("multi_debouncer: illegal parameter combination");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic             meta_r;
        logic             sync_r;
        state_t           state_r;
        state_t           state_s;
        logic [CNT_W-1:0] cnt_r;
        logic [CNT_W-1:0] cnt_s;
        logic             press_s;
        logic             release_s;
        logic             long_s;
        logic             level_r;
        logic             press_r;
        logic             release_r;
        logic             busy_r;
`ifdef DEBOUNCE_LONGPRESS_EN
        localparam int                HCNT_W    = $clog2(LONG_TICKS + 1);
        localparam logic [HCNT_W-1:0] HCNT_MAX  = HCNT_W'(LONG_TICKS);
        localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(LONG_TICKS - 1);
        logic [HCNT_W-1:0] hcnt_r;
        logic [HCNT_W-1:0] hcnt_s;
        logic              long_r;
`endif

        // two-flop synchroniser for the asynchronous button pin
        always_ff @(posedge clk) begin
            if (rst) begin
                meta_r <= 1'b0;
                sync_r <= 1'b0;
            end else begin
                meta_r <= p_in[i];
                sync_r <= meta_r;
            end
        end

        // next-state logic; an input change always wins over a same-cycle tick
        always_comb begin
            state_s   = state_r;
            cnt_s     = cnt_r;
            press_s   = 1'b0;
            release_s = 1'b0;
            long_s    = 1'b0;
`ifdef DEBOUNCE_LONGPRESS_EN
            hcnt_s    = hcnt_r;
`endif
            case (state_r)
                IDLE: begin
                    if (sync_r) begin
                        state_s = PRESS_WAIT;
                        cnt_s   = '0;
                    end else begin
                        state_s = IDLE;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync_r) begin
                        state_s = IDLE;
                    end else if (tick) begin
                        if (cnt_r == STABLE_LAST) begin
                            state_s = HELD;
                            press_s = 1'b1;
`ifdef DEBOUNCE_LONGPRESS_EN
                            hcnt_s  = '0;
`endif
                        end else begin
                            cnt_s = cnt_r + CNT_W'(1);
                        end
                    end else begin
                        state_s = PRESS_WAIT;
                    end
                end
                HELD: begin
                    if (!sync_r) begin
                        state_s = RELEASE_WAIT;
                        cnt_s   = '0;
                    end else begin
                        state_s = HELD;
`ifdef DEBOUNCE_LONGPRESS_EN
                        if (tick && (hcnt_r != HCNT_MAX)) begin
                            hcnt_s = hcnt_r + HCNT_W'(1);
                            long_s = (hcnt_r == HCNT_LAST);
                        end else begin
                            hcnt_s = hcnt_r;
                        end
`endif
                    end
                end
                RELEASE_WAIT: begin
                    if (sync_r) begin
                        state_s = HELD;
                    end else if (tick) begin
                        if (cnt_r == STABLE_LAST) begin
                            state_s   = IDLE;
                            release_s = 1'b1;
                        end else begin
                            cnt_s = cnt_r + CNT_W'(1);
                        end
                    end else begin
                        state_s = RELEASE_WAIT;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = '0;
                end
            endcase
        end

        // state, counter and registered outputs aligned with the new state
        always_ff @(posedge clk) begin
            if (rst) begin
                state_r   <= IDLE;
                cnt_r     <= '0;
                level_r   <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
                busy_r    <= 1'b0;
            end else begin
                state_r   <= state_s;
                cnt_r     <= cnt_s;
                level_r   <= (state_s == HELD) || (state_s == RELEASE_WAIT);
                press_r   <= press_s;
                release_r <= release_s;
                busy_r    <= (state_s == PRESS_WAIT) || (state_s == RELEASE_WAIT);
            end
        end

`ifdef DEBOUNCE_LONGPRESS_EN
        // saturating hold counter and its one-shot long-press pulse
        always_ff @(posedge clk) begin
            if (rst) begin
                hcnt_r <= '0;
                long_r <= 1'b0;
            end else begin
                hcnt_r <= hcnt_s;
                long_r <= long_s;
            end
        end
        assign long_press[i] = long_r;
`else
        assign long_press[i] = long_s;
`endif

        assign level[i]         = level_r;
        assign press[i]         = press_r;
        assign release_pulse[i] = release_r;
        assign busy[i]          = busy_r;
    end

endmodule

// File: tb/tb_multi_debouncer.sv
// Self-checking bench for multi_debouncer: directed scenarios plus random
// stimulus compared every cycle against a level/pending reference model.
module tb_multi_debouncer;
    localparam int CH = 4;
    localparam int ST = 2;
    localparam int CW = 4;
    localparam int LT = 4;
`ifdef DEBOUNCE_LONGPRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0;
    logic [CH-1:0] p_in = '0;
    logic [CH-1:0] level, press, release_pulse, long_press, busy;

    int total = 0;
    int bad   = 0;

    // reference model: debounced level, pending flag, tick counts, 2-deep input delay
    logic [CH-1:0] m_level = '0;
    logic [CH-1:0] m_pend  = '0;
    int            m_cnt  [CH];
    int            m_hold [CH];
    logic [CH-1:0] m1 = '0;
    logic [CH-1:0] m2 = '0;
    logic [CH-1:0] e_press = '0;
    logic [CH-1:0] e_rel   = '0;
    logic [CH-1:0] e_long  = '0;

    multi_debouncer #(
        .CHANNELS    (CH),
        .STABLE_TICKS(ST),
        .CNT_W       (CW),
        .LONG_TICKS  (LT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .p_in         (p_in),
        .level        (level),
        .press        (press),
        .release_pulse(release_pulse),
        .long_press   (long_press),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic model_update();
        logic s;
        for (int c = 0; c < CH; c++) begin
            s = m2[c];
            e_press[c] = 1'b0;
            e_rel[c]   = 1'b0;
            e_long[c]  = 1'b0;
            if (rst) begin
                m_level[c] = 1'b0;
                m_pend[c]  = 1'b0;
                m_cnt[c]   = 0;
                m_hold[c]  = 0;
            end else if (s == m_level[c]) begin
                if (m_level[c] && !m_pend[c] && tick && m_hold[c] < LT) begin
                    m_hold[c]++;
                    if (m_hold[c] == LT) e_long[c] = LP_EN;
                end
                m_pend[c] = 1'b0;
            end else if (!m_pend[c]) begin
                m_pend[c] = 1'b1;
                m_cnt[c]  = 0;
            end else if (tick) begin
                m_cnt[c]++;
                if (m_cnt[c] == ST) begin
                    m_level[c] = ~m_level[c];
                    m_pend[c]  = 1'b0;
                    if (m_level[c]) begin
                        e_press[c] = 1'b1;
                        m_hold[c]  = 0;
                    end else begin
                        e_rel[c] = 1'b1;
                    end
                end
            end
        end
        if (rst) begin
            m2 = '0;
            m1 = '0;
        end else begin
            m2 = m1;
            m1 = p_in;
        end
    endtask

    task automatic run_cycle(input logic r, input logic [CH-1:0] p, input logic t);
        rst  = r;
        p_in = p;
        tick = t;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b1, 4'hF, 1'b0);
            total++;
            if ({level, press, release_pulse, long_press, busy} !== 20'h0) begin
                bad++;
                $display("FAIL reset_outputs got=%h exp=0", {level, press, release_pulse, long_press, busy});
            end
        end
        run_cycle(1'b0, 4'hF, 1'b0);
        run_cycle(1'b0, 4'hF, 1'b0);
        total++;
        if (busy !== 4'h0 || level !== 4'h0) begin
            bad++;
            $display("FAIL reset_sync_delay busy=%b level=%b exp busy=0000 level=0000", busy, level);
        end
        run_cycle(1'b0, 4'hF, 1'b0);
        total++;
        if (busy !== 4'hF) begin
            bad++;
            $display("FAIL reset_sync_arrive busy=%b exp=1111", busy);
        end
    endtask

    task automatic test_clean_press();
        int pc = 0;
        int other = 0;
        run_cycle(1'b1, 4'h0, 1'b0);
        for (int n = 0; n < 40; n++) begin
            run_cycle(1'b0, 4'b0001, (n % 8) == 7);
            total++;
            if ({level, press, release_pulse, long_press, busy} !== {m_level, e_press, e_rel, e_long, m_pend}) begin
                bad++;
                $display("FAIL clean_press n=%0d got=%b exp=%b", n,
                         {level, press, release_pulse, long_press, busy}, {m_level, e_press, e_rel, e_long, m_pend});
            end
            if (press[0]) pc++;
            if ((press[3:1] | level[3:1] | busy[3:1]) != 3'b000) other++;
        end
        total++;
        if (pc !== 1 || level[0] !== 1'b1 || other !== 0) begin
            bad++;
            $display("FAIL clean_press_summary presses=%0d level0=%b other=%0d exp 1/1/0", pc, level[0], other);
        end
    endtask

    task automatic test_bounce();
        int pc = 0;
        int rc = 0;
        logic b;
        run_cycle(1'b1, 4'h0, 1'b0);
        for (int n = 0; n < 70; n++) begin
            b = (n < 10) || (n >= 30 && !(n >= 50 && n < 55));
            run_cycle(1'b0, {2'b00, b, 1'b0}, (n % 8) == 7);
            total++;
            if ({level, press, release_pulse, long_press, busy} !== {m_level, e_press, e_rel, e_long, m_pend}) begin
                bad++;
                $display("FAIL bounce n=%0d got=%b exp=%b", n,
                         {level, press, release_pulse, long_press, busy}, {m_level, e_press, e_rel, e_long, m_pend});
            end
            if (press[1]) pc++;
            if (release_pulse[1]) rc++;
            if (n == 29) begin
                total++;
                if (pc !== 0 || level[1] !== 1'b0 || busy[1] !== 1'b0) begin
                    bad++;
                    $display("FAIL bounce_press_abort presses=%0d level1=%b busy1=%b exp 0/0/0", pc, level[1], busy[1]);
                end
            end
        end
        total++;
        if (pc !== 1 || rc !== 0 || level[1] !== 1'b1) begin
            bad++;
            $display("FAIL bounce_release presses=%0d releases=%0d level1=%b exp 1/0/1", pc, rc, level[1]);
        end
    endtask

    task automatic test_release();
        int rc = 0;
        int lvl_bad = 0;
        run_cycle(1'b1, 4'h0, 1'b0);
        for (int n = 0; n < 64; n++) begin
            run_cycle(1'b0, {1'b0, (n < 40), 2'b00}, (n % 8) == 7);
            total++;
            if ({level, press, release_pulse, long_press, busy} !== {m_level, e_press, e_rel, e_long, m_pend}) begin
                bad++;
                $display("FAIL release n=%0d got=%b exp=%b", n,
                         {level, press, release_pulse, long_press, busy}, {m_level, e_press, e_rel, e_long, m_pend});
            end
            if (release_pulse[2]) begin
                rc++;
                if (level[2] !== 1'b0 || n != 55) lvl_bad++;
            end
        end
        total++;
        if (rc !== 1 || lvl_bad !== 0 || level[2] !== 1'b0) begin
            bad++;
            $display("FAIL release_pulse releases=%0d misaligned=%0d level2=%b exp 1/0/0", rc, lvl_bad, level[2]);
        end
    endtask

    task automatic test_long_press();
        int lc = 0;
        int at = -1;
        run_cycle(1'b1, 4'h0, 1'b0);
        for (int n = 0; n < 100; n++) begin
            run_cycle(1'b0, 4'b1000, (n % 8) == 7);
            total++;
            if ({level, press, release_pulse, long_press, busy} !== {m_level, e_press, e_rel, e_long, m_pend}) begin
                bad++;
                $display("FAIL long_press n=%0d got=%b exp=%b", n,
                         {level, press, release_pulse, long_press, busy}, {m_level, e_press, e_rel, e_long, m_pend});
            end
            if (long_press != 4'b0000) begin
                lc++;
                at = n;
            end
        end
        total++;
        if (lc !== (LP_EN ? 1 : 0) || at !== (LP_EN ? 47 : -1)) begin
            bad++;
            $display("FAIL long_press_once count=%0d at=%0d exp count=%0d at=%0d",
                     lc, at, LP_EN ? 1 : 0, LP_EN ? 47 : -1);
        end
    endtask

    task automatic test_simultaneous();
        int pc = 0;
        int rc = 0;
        run_cycle(1'b1, 4'h0, 1'b0);
        for (int n = 0; n < 30; n++) begin
            run_cycle(1'b0, {3'b000, (n < 13)}, (n % 8) == 7);
            if (press[0]) pc++;
        end
        total++;
        if (pc !== 0 || level[0] !== 1'b0 || busy[0] !== 1'b0) begin
            bad++;
            $display("FAIL simul_drop_tick presses=%0d level0=%b busy0=%b exp 0/0/0", pc, level[0], busy[0]);
        end
        run_cycle(1'b1, 4'h0, 1'b0);
        for (int n = 0; n < 20; n++) run_cycle(1'b0, 4'b0001, (n % 8) == 7);
        total++;
        if (level[0] !== 1'b1) begin
            bad++;
            $display("FAIL simul_held_setup level0=%b exp=1", level[0]);
        end
        run_cycle(1'b1, 4'b0001, 1'b0);
        total++;
        if ({level, press, release_pulse, long_press, busy} !== 20'h0) begin
            bad++;
            $display("FAIL simul_reset_held got=%h exp=0", {level, press, release_pulse, long_press, busy});
        end
        for (int n = 0; n < 20; n++) begin
            run_cycle(1'b0, 4'h0, (n % 8) == 7);
            if (release_pulse[0]) rc++;
        end
        total++;
        if (rc !== 0 || level !== 4'h0) begin
            bad++;
            $display("FAIL simul_no_release releases=%0d level=%b exp 0/0000", rc, level);
        end
    endtask

    task automatic test_random();
        logic [CH-1:0] p = '0;
        logic          r;
        run_cycle(1'b1, 4'h0, 1'b0);
        for (int n = 0; n < 4000; n++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 11) == 0) p[c] = ~p[c];
            end
            r = ($urandom_range(0, 499) == 0);
            run_cycle(r, p, $urandom_range(0, 5) == 0);
            total++;
            if ({level, press, release_pulse, long_press, busy} !== {m_level, e_press, e_rel, e_long, m_pend}) begin
                bad++;
                $display("FAIL random n=%0d got=%b exp=%b", n,
                         {level, press, release_pulse, long_press, busy}, {m_level, e_press, e_rel, e_long, m_pend});
            end
        end
    endtask

    initial begin
        for (int c = 0; c < CH; c++) begin
            m_cnt[c]  = 0;
            m_hold[c] = 0;
        end
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_long_press();
        test_simultaneous();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
